note_sequencer: RTL and testbench
=================================

# note_sequencer

Sequences the shared note-duration `timer` through a song stored in a synchronous ROM. The ROM holds `{note, duration}` entries. For each entry the block fetches it, loads the timer with the duration, and gates the timer's beat enable while playing. When the timer expires, or when the user skips, it advances to the next entry. It sits between the song ROM, the `beat32`/`timer` pair and the note player, and is the only block that drives the timer's load and count-enable gate.

## Interface
- `ADDR_W`, 5, ROM address width (song length up to 2^ADDR_W entries)
- `NOTE_W`, 6, note code width
- `DUR_W`, 7, duration width in beats; matches the timer's `load_value`

- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high; one clock, reset is synchronous and active-high
- `play`  in  1  level: 1 = run, 0 = pause
- `next`  in  1  one-cycle pulse: skip the current note
- `timer_done`  in  1  one-cycle expiry pulse from the timer's `out`
- `rom_data`  in  NOTE_W+DUR_W  `{note, duration}`; valid the cycle after `rom_addr` changes
- `rom_addr`  out  ADDR_W  registered ROM address
- `timer_load`  out  1  one-cycle pulse; drives the timer's load/reset
- `timer_load_value`  out  DUR_W  duration presented with `timer_load`
- `timer_gate`  out  1  ANDed with the `beat32` output to form the timer's `count_en`
- `note_out`  out  NOTE_W  current note code
- `note_valid`  out  1  note should sound
- `song_done`  out  1  end of song reached

## Operation
- States: IDLE, FETCH, DECODE, PLAY, PAUSE, DONE.
- IDLE: waits for `play`=1, then goes to FETCH.
- FETCH: lasts one cycle; the ROM read is in flight. `note_valid`=0.
- DECODE: samples `rom_data`.
  - duration==0 marks end of song: go to DONE.
  - Otherwise: `note_out`<=note, `timer_load_value`<=duration, pulse `timer_load`.
  - If `play`=1: go to PLAY with `note_valid`=1 and `timer_gate`=1.
  - If `play`=0: go to PAUSE.
- PLAY: `timer_gate`=1 and `note_valid`=1.
  - `timer_done` or `next` advances the entry.
  - Otherwise `play`=0 goes to PAUSE.
- PAUSE: `timer_gate`=0 and `note_valid`=0.
  - `play`=1 returns to PLAY.
  - `next` advances the entry.
  - A `timer_done` arriving in PAUSE sets a pending flag. The advance happens on resume instead of returning to PLAY.
- Advance:
  - If `rom_addr`==2^ADDR_W−1: go to DONE with no wrap; `rom_addr` holds.
  - Otherwise `rom_addr`<=`rom_addr`+1 and go to FETCH.
- DONE: `song_done`=1, `note_valid`=0, `timer_gate`=0.
  - On `play`=0: `rom_addr`<=0, `song_done`<=0, go to IDLE.
- Simultaneous `next` and `timer_done`: a single advance.
- `next` in IDLE, FETCH, DECODE or DONE is ignored.
- All outputs are registered.

## Timing
- Reset values:
  - state=IDLE
  - `rom_addr`=0, `timer_load`=0, `timer_load_value`=0, `timer_gate`=0
  - `note_out`=0, `note_valid`=0, `song_done`=0
  - pending flag=0
- `reset` overrides every other input. Reset asserted mid-note returns all outputs to reset values on the next edge, with no `timer_load` pulse.
- Start latency: `play` sampled high in IDLE at edge 0 gives FETCH in cycle 1 and DECODE in cycle 2. `timer_load`=1, `note_valid`=1 and `timer_gate`=1 are visible in cycle 3.
- Advance latency: `timer_done` sampled at edge t gives the new `rom_addr` in cycle t+1. The new note and `timer_load` appear in cycle t+3.
- `note_valid` is low for exactly 2 cycles between consecutive notes. `note_out` holds its old value until DECODE.
- `timer_load` is high for exactly one cycle per note, coincident with the new `timer_load_value`.
- Pause: `play` low sampled at edge p drops `timer_gate` and `note_valid` in cycle p+1. Resume restores both one cycle after `play` is sampled high.
- `song_done` rises one cycle after the terminating DECODE or the final advance.

## Test plan
- Basic play: ROM = {n=5,d=2},{n=9,d=1},{0,0}; `play`=1 after reset. Required: `timer_load` pulses with value 2 then 1; `note_out` goes 5 then 9; `song_done`=1 three cycles after the second `timer_done`.
- Pause: pause during note 5, pulse `timer_done` while paused, then resume. Required: `timer_gate`=0 throughout the pause; advance to note 9 on resume, with no return to PLAY of note 5.
- Skip: assert `next` and `timer_done` in the same cycle. Required: `rom_addr` increments by exactly 1.
- End of ROM: ADDR_W=2 with four nonzero entries. Required: after the 4th expiry, DONE is entered with `rom_addr`=3 and no wrap. Then `play`=0 gives IDLE with `rom_addr`=0.
- Reset mid-note: reset during PLAY of entry 1. Required: all outputs take reset values on the next edge; replay starts from address 0.
- Start while paused: `next` pulsed in IDLE, then `play`=1. Required: `next` has no effect and the first note is entry 0.

Source files
------------

// File: rtl/note_sequencer_if.sv
// Bundle of play controls, song-ROM bus and timer/note-player signals around note_sequencer.
// The master modport is the sequencer side; the slave modport is the surrounding environment.
interface note_sequencer_if #(
    parameter int ADDR_W = 5,
    parameter int NOTE_W = 6,
    parameter int DUR_W  = 7
);
    logic                      play;
    logic                      next;
    logic                      timer_done;
    logic [NOTE_W+DUR_W-1:0]   rom_data;
    logic [ADDR_W-1:0]         rom_addr;
    logic                      timer_load;
    logic [DUR_W-1:0]          timer_load_value;
    logic                      timer_gate;
    logic [NOTE_W-1:0]         note_out;
    logic                      note_valid;
    logic                      song_done;

    modport master (
        input  play, next, timer_done, rom_data,
        output rom_addr, timer_load, timer_load_value, timer_gate,
               note_out, note_valid, song_done
    );

    modport slave (
        output play, next, timer_done, rom_data,
        input  rom_addr, timer_load, timer_load_value, timer_gate,
               note_out, note_valid, song_done
    );
endinterface

// File: rtl/note_sequencer.sv
// Walks a song ROM of {note, duration} entries, loading and gating the shared note timer.
// A zero duration or running past the last address ends the song.
module note_sequencer #(
    parameter int ADDR_W = 5,
    parameter int NOTE_W = 6,
    parameter int DUR_W  = 7
) (
    input  logic                 clk,
    input  logic                 reset,
    note_sequencer_if.master     bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_PLAY   = 3'd3,
        S_PAUSE  = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t              state_r;
    logic [ADDR_W-1:0]   rom_addr_r;
    logic                timer_load_r;
    logic [DUR_W-1:0]    timer_load_value_r;
    logic                timer_gate_r;
    logic [NOTE_W-1:0]   note_out_r;
    logic                note_valid_r;
    logic                song_done_r;
    logic                pending_r;

    logic                advance_s;
    logic                at_last_s;
    logic [NOTE_W-1:0]   rom_note_s;
    logic [DUR_W-1:0]    rom_dur_s;

    assign rom_note_s = bus.rom_data[NOTE_W+DUR_W-1:DUR_W];
    assign rom_dur_s  = bus.rom_data[DUR_W-1:0];
    assign at_last_s  = (rom_addr_r == {ADDR_W{1'b1}});

    // Decide when the current entry is finished; next and timer_done together still mean one step.
    always_comb begin
        advance_s = 1'b0;
        case (state_r)
            S_PLAY:  advance_s = bus.timer_done | bus.next;
            S_PAUSE: advance_s = bus.next | (bus.play & (pending_r | bus.timer_done));
            default: advance_s = 1'b0;
        endcase
    end

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r            <= S_IDLE;
            rom_addr_r         <= {ADDR_W{1'b0}};
            timer_load_r       <= 1'b0;
            timer_load_value_r <= {DUR_W{1'b0}};
            timer_gate_r       <= 1'b0;
            note_out_r         <= {NOTE_W{1'b0}};
            note_valid_r       <= 1'b0;
            song_done_r        <= 1'b0;
            pending_r          <= 1'b0;
        end else begin
            timer_load_r <= 1'b0;
            if (advance_s) begin
                note_valid_r <= 1'b0;
                timer_gate_r <= 1'b0;
                pending_r    <= 1'b0;
                if (at_last_s) begin
                    // No wrap: the address stays on the last entry while DONE is shown.
                    state_r     <= S_DONE;
                    song_done_r <= 1'b1;
                end else begin
                    rom_addr_r <= rom_addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                    state_r    <= S_FETCH;
                end
            end else begin
                case (state_r)
                    S_IDLE: begin
                        if (bus.play) begin
                            state_r <= S_FETCH;
                        end else begin
                            state_r <= S_IDLE;
                        end
                    end
                    S_FETCH: begin
                        note_valid_r <= 1'b0;
                        timer_gate_r <= 1'b0;
                        pending_r    <= 1'b0;
                        state_r      <= S_DECODE;
                    end
                    S_DECODE: begin
                        if (rom_dur_s == {DUR_W{1'b0}}) begin
                            state_r      <= S_DONE;
                            song_done_r  <= 1'b1;
                            note_valid_r <= 1'b0;
                            timer_gate_r <= 1'b0;
                        end else begin
                            note_out_r         <= rom_note_s;
                            timer_load_value_r <= rom_dur_s;
                            timer_load_r       <= 1'b1;
                            if (bus.play) begin
                                state_r      <= S_PLAY;
                                note_valid_r <= 1'b1;
                                timer_gate_r <= 1'b1;
                            end else begin
                                state_r      <= S_PAUSE;
                                note_valid_r <= 1'b0;
                                timer_gate_r <= 1'b0;
                            end
                        end
                    end
                    S_PLAY: begin
                        if (!bus.play) begin
                            state_r      <= S_PAUSE;
                            note_valid_r <= 1'b0;
                            timer_gate_r <= 1'b0;
                        end else begin
                            state_r <= S_PLAY;
                        end
                    end
                    S_PAUSE: begin
                        if (bus.play) begin
                            state_r      <= S_PLAY;
                            note_valid_r <= 1'b1;
                            timer_gate_r <= 1'b1;
                        end else if (bus.timer_done) begin
                            // Expiry while paused is remembered and acted on at resume.
                            pending_r <= 1'b1;
                        end else begin
                            state_r <= S_PAUSE;
                        end
                    end
                    S_DONE: begin
                        note_valid_r <= 1'b0;
                        timer_gate_r <= 1'b0;
                        if (!bus.play) begin
                            rom_addr_r  <= {ADDR_W{1'b0}};
                            song_done_r <= 1'b0;
                            state_r     <= S_IDLE;
                        end else begin
                            song_done_r <= 1'b1;
                        end
                    end
                    default: begin
                        state_r <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.rom_addr         = rom_addr_r;
    assign bus.timer_load       = timer_load_r;
    assign bus.timer_load_value = timer_load_value_r;
    assign bus.timer_gate       = timer_gate_r;
    assign bus.note_out         = note_out_r;
    assign bus.note_valid       = note_valid_r;
    assign bus.song_done        = song_done_r;

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer: a 32-entry song instance and a 4-entry (ADDR_W=2) instance,
// each fed by a synchronous ROM model.
module tb_note_sequencer;

    logic clk = 1'b0;
    logic reset_a;
    logic reset_b;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    note_sequencer_if #(.ADDR_W(5), .NOTE_W(6), .DUR_W(7)) bus_a ();
    note_sequencer_if #(.ADDR_W(2), .NOTE_W(6), .DUR_W(7)) bus_b ();

    note_sequencer #(.ADDR_W(5), .NOTE_W(6), .DUR_W(7)) dut_a (
        .clk(clk), .reset(reset_a), .bus(bus_a.master)
    );
    note_sequencer #(.ADDR_W(2), .NOTE_W(6), .DUR_W(7)) dut_b (
        .clk(clk), .reset(reset_b), .bus(bus_b.master)
    );

    logic [12:0] rom_a [32];
    logic [12:0] rom_b [4];
    logic [5:0]  note_b [4];
    logic [6:0]  dur_b  [4];

    always @(posedge clk) begin
        bus_a.rom_data <= rom_a[bus_a.rom_addr];
        bus_b.rom_data <= rom_b[bus_b.rom_addr];
    end

    typedef struct {
        logic       play;
        logic       next;
        logic       td;
        logic [4:0] addr;
        logic       load;
        logic [6:0] val;
        logic       gate;
        logic [5:0] note;
        logic       nv;
        logic       sd;
    } vec_t;

    vec_t vecs [13];

    function automatic logic [31:0] exp_a(input logic [4:0] addr, input logic load,
                                          input logic [6:0] val, input logic gate,
                                          input logic [5:0] note, input logic nv, input logic sd);
        return {10'd0, addr, load, val, gate, note, nv, sd};
    endfunction

    function automatic logic [31:0] obs_a();
        return {10'd0, bus_a.rom_addr, bus_a.timer_load, bus_a.timer_load_value,
                bus_a.timer_gate, bus_a.note_out, bus_a.note_valid, bus_a.song_done};
    endfunction

    function automatic logic [31:0] obs_b();
        return {13'd0, bus_b.rom_addr, bus_b.timer_load, bus_b.timer_load_value,
                bus_b.timer_gate, bus_b.note_out, bus_b.note_valid, bus_b.song_done};
    endfunction

    function automatic logic [31:0] exp_b(input logic [1:0] addr, input logic load,
                                          input logic [6:0] val, input logic gate,
                                          input logic [5:0] note, input logic nv, input logic sd);
        return {13'd0, addr, load, val, gate, note, nv, sd};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (addr,load,val,gate,note,nv,sd)", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut_a();
        bus_a.play = 1'b0; bus_a.next = 1'b0; bus_a.timer_done = 1'b0;
        reset_a = 1'b1;
        step();
        reset_a = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rom_a[i] = 13'd0;
        rom_a[0] = {6'd5, 7'd2};
        rom_a[1] = {6'd9, 7'd1};
        rom_a[2] = {6'd0, 7'd0};
        note_b[0] = 6'd3; dur_b[0] = 7'd1;
        note_b[1] = 6'd4; dur_b[1] = 7'd1;
        note_b[2] = 6'd7; dur_b[2] = 7'd2;
        note_b[3] = 6'd8; dur_b[3] = 7'd1;
        for (int i = 0; i < 4; i++) rom_b[i] = {note_b[i], dur_b[i]};

        vecs[0]  = '{1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 7'd0, 1'b0, 6'd0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 7'd0, 1'b0, 6'd0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 7'd2, 1'b1, 6'd5, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 7'd2, 1'b1, 6'd5, 1'b1, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 1'b1, 5'd1, 1'b0, 7'd2, 1'b0, 6'd5, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 5'd1, 1'b0, 7'd2, 1'b0, 6'd5, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 5'd1, 1'b1, 7'd1, 1'b1, 6'd9, 1'b1, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 1'b1, 5'd2, 1'b0, 7'd1, 1'b0, 6'd9, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 5'd2, 1'b0, 7'd1, 1'b0, 6'd9, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 5'd2, 1'b0, 7'd1, 1'b0, 6'd9, 1'b0, 1'b1};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 5'd2, 1'b0, 7'd1, 1'b0, 6'd9, 1'b0, 1'b1};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 7'd1, 1'b0, 6'd9, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 7'd1, 1'b0, 6'd9, 1'b0, 1'b0};

        bus_b.play = 1'b0; bus_b.next = 1'b0; bus_b.timer_done = 1'b0;
        reset_b = 1'b1;

        // Reset values and basic play table
        reset_dut_a();
        check("reset_values", obs_a(), exp_a(5'd0, 1'b0, 7'd0, 1'b0, 6'd0, 1'b0, 1'b0));
        for (int i = 0; i < 13; i++) begin
            bus_a.play = vecs[i].play;
            bus_a.next = vecs[i].next;
            bus_a.timer_done = vecs[i].td;
            step();
            check($sformatf("basic_v%0d", i), obs_a(),
                  exp_a(vecs[i].addr, vecs[i].load, vecs[i].val, vecs[i].gate,
                        vecs[i].note, vecs[i].nv, vecs[i].sd));
        end
        bus_a.timer_done = 1'b0;

        // Pause with expiry while paused, then skip with next+timer_done together
        reset_dut_a();
        bus_a.play = 1'b1;
        step(); step(); step();
        check("pause_setup", obs_a(), exp_a(5'd0, 1'b1, 7'd2, 1'b1, 6'd5, 1'b1, 1'b0));
        bus_a.play = 1'b0;
        step();
        check("pause_gate_off", obs_a(), exp_a(5'd0, 1'b0, 7'd2, 1'b0, 6'd5, 1'b0, 1'b0));
        bus_a.timer_done = 1'b1;
        step();
        bus_a.timer_done = 1'b0;
        check("pause_td", obs_a(), exp_a(5'd0, 1'b0, 7'd2, 1'b0, 6'd5, 1'b0, 1'b0));
        step();
        check("pause_hold", obs_a(), exp_a(5'd0, 1'b0, 7'd2, 1'b0, 6'd5, 1'b0, 1'b0));
        bus_a.play = 1'b1;
        step();
        check("resume_advance", obs_a(), exp_a(5'd1, 1'b0, 7'd2, 1'b0, 6'd5, 1'b0, 1'b0));
        step(); step();
        check("resume_note9", obs_a(), exp_a(5'd1, 1'b1, 7'd1, 1'b1, 6'd9, 1'b1, 1'b0));
        bus_a.next = 1'b1; bus_a.timer_done = 1'b1;
        step();
        bus_a.next = 1'b0; bus_a.timer_done = 1'b0;
        check("skip_addr", obs_a(), exp_a(5'd2, 1'b0, 7'd1, 1'b0, 6'd9, 1'b0, 1'b0));
        step();
        check("skip_fetch", obs_a(), exp_a(5'd2, 1'b0, 7'd1, 1'b0, 6'd9, 1'b0, 1'b0));
        step();
        check("skip_done", obs_a(), exp_a(5'd2, 1'b0, 7'd1, 1'b0, 6'd9, 1'b0, 1'b1));

        // Reset during PLAY of entry 1, then replay from address 0
        reset_dut_a();
        bus_a.play = 1'b1;
        step(); step(); step();
        bus_a.timer_done = 1'b1;
        step();
        bus_a.timer_done = 1'b0;
        step(); step();
        check("midreset_setup", obs_a(), exp_a(5'd1, 1'b1, 7'd1, 1'b1, 6'd9, 1'b1, 1'b0));
        reset_a = 1'b1; bus_a.timer_done = 1'b1; bus_a.next = 1'b1;
        step();
        check("midreset_values", obs_a(), exp_a(5'd0, 1'b0, 7'd0, 1'b0, 6'd0, 1'b0, 1'b0));
        reset_a = 1'b0; bus_a.timer_done = 1'b0; bus_a.next = 1'b0;
        step(); step(); step();
        check("midreset_replay", obs_a(), exp_a(5'd0, 1'b1, 7'd2, 1'b1, 6'd5, 1'b1, 1'b0));

        // next while idle is ignored
        reset_dut_a();
        bus_a.next = 1'b1;
        step();
        bus_a.next = 1'b0;
        check("idle_next", obs_a(), exp_a(5'd0, 1'b0, 7'd0, 1'b0, 6'd0, 1'b0, 1'b0));
        bus_a.play = 1'b1;
        step(); step(); step();
        check("idle_next_first", obs_a(), exp_a(5'd0, 1'b1, 7'd2, 1'b1, 6'd5, 1'b1, 1'b0));
        bus_a.play = 1'b0;

        // End of ROM on the 4-entry instance: no wrap, then back to IDLE at address 0
        step();
        reset_b = 1'b0;
        bus_b.play = 1'b1;
        step(); step(); step();
        check("eor_first", obs_b(), exp_b(2'd0, 1'b1, dur_b[0], 1'b1, note_b[0], 1'b1, 1'b0));
        for (int k = 0; k < 4; k++) begin
            bus_b.timer_done = 1'b1;
            step();
            bus_b.timer_done = 1'b0;
            if (k < 3) begin
                check($sformatf("eor_adv%0d", k), obs_b(),
                      exp_b(2'(k + 1), 1'b0, dur_b[k], 1'b0, note_b[k], 1'b0, 1'b0));
                step(); step();
                check($sformatf("eor_note%0d", k + 1), obs_b(),
                      exp_b(2'(k + 1), 1'b1, dur_b[k + 1], 1'b1, note_b[k + 1], 1'b1, 1'b0));
            end else begin
                check("eor_done", obs_b(), exp_b(2'd3, 1'b0, dur_b[3], 1'b0, note_b[3], 1'b0, 1'b1));
            end
        end
        step();
        check("eor_hold", obs_b(), exp_b(2'd3, 1'b0, dur_b[3], 1'b0, note_b[3], 1'b0, 1'b1));
        bus_b.play = 1'b0;
        step();
        check("eor_idle", obs_b(), exp_b(2'd0, 1'b0, dur_b[3], 1'b0, note_b[3], 1'b0, 1'b0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
